// File: rtl/pipe_collision_scorer_if.sv
// Bus between the pipe/player position generators, the collision scorer and the display side.
// The best_score signal exists only when BEST_SCORE_EN is defined.
interface pipe_collision_scorer_if;
  logic        frame_tick;
  logic        start;
  logic [10:0] pipe_x;
  logic [9:0]  pipe_y;
  logic [10:0] player_x;
  logic [9:0]  player_y;
  logic        pipe_init;
  logic [7:0]  score;
  logic        game_over;
  logic        hit_flash;
  logic [1:0]  state;
`ifdef BEST_SCORE_EN
  logic [7:0]  best_score;
`endif

  modport master (
`ifdef BEST_SCORE_EN
    input  best_score,
`endif
    output frame_tick, start, pipe_x, pipe_y, player_x, player_y,
    input  pipe_init, score, game_over, hit_flash, state
  );

  modport slave (
`ifdef BEST_SCORE_EN
    output best_score,
`endif
    input  frame_tick, start, pipe_x, pipe_y, player_x, player_y,
    output pipe_init, score, game_over, hit_flash, state
  );
endinterface

// File: rtl/pipe_collision_scorer.sv
// Per-frame collision detection, BCD pipe scoring and game-state FSM (IDLE/PLAY/HIT/OVER).
// Optional BEST_SCORE_EN adds a best_score register that survives restarts.
module pipe_collision_scorer #(
  parameter int PIPE_W     = 40,
  parameter int GAP_H      = 120,
  parameter int PLAYER_W   = 20,
  parameter int PLAYER_H   = 20,
  parameter int GROUND_Y   = 460,
  parameter int WRAP_X     = 1536,
  parameter int HIT_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  pipe_collision_scorer_if.slave bus
);

  localparam int CNT_W = $clog2(HIT_FRAMES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [7:0]  score_q, score_d;
  logic        pipe_init_q, pipe_init_d;
  logic        game_over_q, game_over_d;
  logic        hit_flash_q, hit_flash_d;
  logic        pass_flag_q, pass_flag_d;
  logic        armed_q, armed_d;
  logic [10:0] pipe_x_q, pipe_x_d, prev_x_q, prev_x_d, player_x_q, player_x_d;
  logic [9:0]  pipe_y_q, pipe_y_d, player_y_q, player_y_d;
  logic        sample_valid_q, sample_valid_d, prev_valid_q, prev_valid_d;
  logic        s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic        hit_f_q, hit_f_d, passed_f_q, passed_f_d, respawn_f_q, respawn_f_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
`ifdef BEST_SCORE_EN
  logic [7:0]  best_q, best_d;
`endif

  logic       wrap, overlap_x, outside_gap, ground, respawn, passed, hit, accept, pf;
  logic [7:0] score_inc;

  assign wrap        = pipe_x_q >= 11'(WRAP_X);
  assign overlap_x   = !wrap
                       && (({1'b0, player_x_q} + 12'(PLAYER_W)) > {1'b0, pipe_x_q})
                       && ({1'b0, player_x_q} < ({1'b0, pipe_x_q} + 12'(PIPE_W)));
  assign outside_gap = ({1'b0, player_y_q} < {1'b0, pipe_y_q})
                       || (({1'b0, player_y_q} + 11'(PLAYER_H)) > ({1'b0, pipe_y_q} + 11'(GAP_H)));
  assign ground      = ({1'b0, player_y_q} + 11'(PLAYER_H)) >= 11'(GROUND_Y);
  assign respawn     = prev_valid_q && (pipe_x_q > prev_x_q);
  assign passed      = (({1'b0, pipe_x_q} + 12'(PIPE_W)) <= {1'b0, player_x_q}) || wrap;
  assign hit         = (overlap_x && outside_gap) || ground;
  // A tick arriving while a frame is still in S2 or S3 is dropped.
  assign accept      = bus.frame_tick && !s2_valid_q && !s3_valid_q;

  always_comb begin
    score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    if (score_q == 8'h99)
      score_inc = score_q;
    else if (score_q[3:0] == 4'd9)
      score_inc = {score_q[7:4] + 4'd1, 4'd0};
  end

  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    pipe_init_d    = pipe_init_q;
    game_over_d    = game_over_q;
    hit_flash_d    = hit_flash_q;
    pass_flag_d    = pass_flag_q;
    armed_d        = armed_q;
    pipe_x_d       = pipe_x_q;
    pipe_y_d       = pipe_y_q;
    player_x_d     = player_x_q;
    player_y_d     = player_y_q;
    prev_x_d       = prev_x_q;
    sample_valid_d = sample_valid_q;
    prev_valid_d   = prev_valid_q;
    hit_cnt_d      = hit_cnt_q;
    s2_valid_d     = 1'b0;
    s3_valid_d     = s2_valid_q;
    hit_f_d        = s2_valid_q ? hit     : hit_f_q;
    passed_f_d     = s2_valid_q ? passed  : passed_f_q;
    respawn_f_d    = s2_valid_q ? respawn : respawn_f_q;
    pf             = respawn_f_q ? 1'b0 : pass_flag_q;
`ifdef BEST_SCORE_EN
    best_d         = best_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept && bus.start) begin
          state_d        = PLAY;
          score_d        = 8'h00;
          pass_flag_d    = 1'b0;
          sample_valid_d = 1'b0;
          prev_valid_d   = 1'b0;
          pipe_init_d    = 1'b0;
        end
      end
      PLAY: begin
        if (accept) begin
          pipe_x_d       = bus.pipe_x;
          pipe_y_d       = bus.pipe_y;
          player_x_d     = bus.player_x;
          player_y_d     = bus.player_y;
          prev_x_d       = pipe_x_q;
          prev_valid_d   = sample_valid_q;
          sample_valid_d = 1'b1;
          s2_valid_d     = 1'b1;
        end
        // Hit takes priority over a pass landing in the same frame.
        if (s3_valid_q) begin
          if (hit_f_q) begin
            state_d   = HIT;
            hit_cnt_d = CNT_W'(HIT_FRAMES - 1);
          end else begin
            pass_flag_d = pf;
            if (passed_f_q && !pf) begin
              score_d     = score_inc;
              pass_flag_d = 1'b1;
            end
          end
        end
      end
      HIT: begin
        if (accept) begin
          if (hit_cnt_q == '0) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            pipe_init_d = 1'b1;
            hit_flash_d = 1'b0;
            armed_d     = 1'b0;
`ifdef BEST_SCORE_EN
            if (score_q > best_q)
              best_d = score_q;
`endif
          end else begin
            hit_flash_d = ~hit_flash_q;
            hit_cnt_d   = hit_cnt_q - 1'b1;
          end
        end
      end
      OVER: begin
        // Restart needs start to have been seen low at a tick after entering OVER.
        if (accept) begin
          if (!bus.start) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d     = IDLE;
            game_over_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      score_q        <= 8'h00;
      pipe_init_q    <= 1'b1;
      game_over_q    <= 1'b0;
      hit_flash_q    <= 1'b0;
      pass_flag_q    <= 1'b0;
      armed_q        <= 1'b0;
      pipe_x_q       <= '0;
      pipe_y_q       <= '0;
      player_x_q     <= '0;
      player_y_q     <= '0;
      prev_x_q       <= '0;
      sample_valid_q <= 1'b0;
      prev_valid_q   <= 1'b0;
      s2_valid_q     <= 1'b0;
      s3_valid_q     <= 1'b0;
      hit_f_q        <= 1'b0;
      passed_f_q     <= 1'b0;
      respawn_f_q    <= 1'b0;
      hit_cnt_q      <= '0;
`ifdef BEST_SCORE_EN
      best_q         <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      pipe_init_q    <= pipe_init_d;
      game_over_q    <= game_over_d;
      hit_flash_q    <= hit_flash_d;
      pass_flag_q    <= pass_flag_d;
      armed_q        <= armed_d;
      pipe_x_q       <= pipe_x_d;
      pipe_y_q       <= pipe_y_d;
      player_x_q     <= player_x_d;
      player_y_q     <= player_y_d;
      prev_x_q       <= prev_x_d;
      sample_valid_q <= sample_valid_d;
      prev_valid_q   <= prev_valid_d;
      s2_valid_q     <= s2_valid_d;
      s3_valid_q     <= s3_valid_d;
      hit_f_q        <= hit_f_d;
      passed_f_q     <= passed_f_d;
      respawn_f_q    <= respawn_f_d;
      hit_cnt_q      <= hit_cnt_d;
`ifdef BEST_SCORE_EN
      best_q         <= best_d;
`endif
    end
  end

  assign bus.state     = state_q;
  assign bus.score     = score_q;
  assign bus.pipe_init = pipe_init_q;
  assign bus.game_over = game_over_q;
  assign bus.hit_flash = hit_flash_q;
`ifdef BEST_SCORE_EN
  assign bus.best_score = best_q;
`endif

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed testbench for pipe_collision_scorer; best_score checks run only with BEST_SCORE_EN.
module tb_pipe_collision_scorer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] mid_state;
  logic [7:0] mid_score;

  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3;

  pipe_collision_scorer_if bus();

  pipe_collision_scorer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // One frame: tick captured at E0, sample mid after E1, return after E2.
  task automatic frame(input logic st, input logic [10:0] px, input logic [9:0] py,
                       input logic [10:0] plx, input logic [9:0] ply);
    @(posedge clk); #1;
    bus.start = st; bus.pipe_x = px; bus.pipe_y = py;
    bus.player_x = plx; bus.player_y = ply; bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    @(posedge clk); #1;
    mid_state = bus.state;
    mid_score = bus.score;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.pipe_x = '0; bus.pipe_y = '0; bus.player_x = '0; bus.player_y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.state, bus.pipe_init, bus.score, bus.game_over, bus.hit_flash} !== {S_IDLE, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h",
               {bus.state, bus.pipe_init, bus.score, bus.game_over, bus.hit_flash}, {S_IDLE, 1'b1, 8'h00, 1'b0, 1'b0});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frame(1'b0, 11'd500, 10'd150, 11'd100, 10'd200);
      checks++;
      if ({bus.state, bus.pipe_init, bus.score} !== {S_IDLE, 1'b1, 8'h00}) begin
        errors++;
        $display("[TB] FAIL idle_hold frame %0d: got %h expected %h", i, {bus.state, bus.pipe_init, bus.score}, {S_IDLE, 1'b1, 8'h00});
      end
    end
  endtask

  task automatic test_start();
    frame(1'b1, 11'd500, 10'd150, 11'd100, 10'd200);
    checks++;
    if ({bus.state, bus.pipe_init, bus.score} !== {S_PLAY, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL start_play: got %h expected %h", {bus.state, bus.pipe_init, bus.score}, {S_PLAY, 1'b0, 8'h00});
    end
  endtask

  task automatic test_scoring();
    logic [10:0] px;
    logic [7:0]  exp;
    for (int k = 0; k <= 110; k++) begin
      px = 11'(500 - 4 * k);
      frame(1'b0, px, 10'd150, 11'd100, 10'd200);
      exp = (px <= 11'd60) ? 8'h01 : 8'h00;
      checks++;
      if ({bus.state, bus.score} !== {S_PLAY, exp}) begin
        errors++;
        $display("[TB] FAIL approach px=%0d: got %h expected %h", px, {bus.state, bus.score}, {S_PLAY, exp});
      end
      if (px == 11'd60) begin
        checks++;
        if (mid_score !== 8'h00) begin
          errors++;
          $display("[TB] FAIL score_latency: got %h expected %h one cycle after capture", mid_score, 8'h00);
        end
      end
    end
    frame(1'b0, 11'd500, 10'd150, 11'd100, 10'd200);
    frame(1'b0, 11'd496, 10'd150, 11'd100, 10'd200);
    checks++;
    if (bus.score !== 8'h01) begin
      errors++;
      $display("[TB] FAIL after_respawn: got %h expected %h", bus.score, 8'h01);
    end
  endtask

  task automatic test_bcd();
    int model = 1;
    frame(1'b0, 11'd1600, 10'd150, 11'd100, 10'd200);
    model++;
    checks++;
    if (bus.score !== 8'h02) begin
      errors++;
      $display("[TB] FAIL wrap_pass: got %h expected %h", bus.score, 8'h02);
    end
    frame(1'b0, 11'd200, 10'd150, 11'd100, 10'd200);
    frame(1'b0, 11'd300, 10'd150, 11'd100, 10'd200);
    checks++;
    if (bus.score !== 8'h02) begin
      errors++;
      $display("[TB] FAIL no_double_pass: got %h expected %h", bus.score, 8'h02);
    end
    while (model < 99) begin
      frame(1'b0, 11'd60, 10'd150, 11'd100, 10'd200);
      model++;
      checks++;
      if (bus.score !== to_bcd(model)) begin
        errors++;
        $display("[TB] FAIL bcd_inc: got %h expected %h", bus.score, to_bcd(model));
      end
      frame(1'b0, 11'd200, 10'd150, 11'd100, 10'd200);
    end
    frame(1'b0, 11'd60, 10'd150, 11'd100, 10'd200);
    checks++;
    if (bus.score !== 8'h99) begin
      errors++;
      $display("[TB] FAIL bcd_saturate: got %h expected %h", bus.score, 8'h99);
    end
  endtask

  task automatic test_hit_sequence();
    logic prev;
    int   toggles = 0;
    frame(1'b0, 11'd110, 10'd150, 11'd100, 10'd100);
    checks++;
    if ({mid_state, bus.state, bus.score} !== {S_PLAY, S_HIT, 8'h99}) begin
      errors++;
      $display("[TB] FAIL pipe_hit: got %h expected %h", {mid_state, bus.state, bus.score}, {S_PLAY, S_HIT, 8'h99});
    end
    prev = bus.hit_flash;
    for (int i = 1; i <= 30; i++) begin
      frame(1'b0, 11'd110, 10'd150, 11'd100, 10'd100);
      if (bus.hit_flash !== prev) toggles++;
      prev = bus.hit_flash;
      if (i == 29) begin
        checks++;
        if (bus.state !== S_HIT) begin
          errors++;
          $display("[TB] FAIL hit_duration: got %h expected %h after 29 ticks", bus.state, S_HIT);
        end
      end
    end
    checks++;
    if (toggles !== 30) begin
      errors++;
      $display("[TB] FAIL flash_toggles: got %0d expected %0d", toggles, 30);
    end
    checks++;
    if ({bus.state, bus.game_over, bus.pipe_init, bus.hit_flash, bus.score} !== {S_OVER, 1'b1, 1'b1, 1'b0, 8'h99}) begin
      errors++;
      $display("[TB] FAIL over_state: got %h expected %h",
               {bus.state, bus.game_over, bus.pipe_init, bus.hit_flash, bus.score}, {S_OVER, 1'b1, 1'b1, 1'b0, 8'h99});
    end
  endtask

  task automatic test_restart_qualify();
    frame(1'b1, 11'd500, 10'd150, 11'd100, 10'd200);
    checks++;
    if (bus.state !== S_OVER) begin
      errors++;
      $display("[TB] FAIL held_start_ignored: got %h expected %h", bus.state, S_OVER);
    end
    frame(1'b0, 11'd500, 10'd150, 11'd100, 10'd200);
    frame(1'b1, 11'd500, 10'd150, 11'd100, 10'd200);
    checks++;
    if ({bus.state, bus.game_over, bus.pipe_init, bus.score} !== {S_IDLE, 1'b0, 1'b1, 8'h99}) begin
      errors++;
      $display("[TB] FAIL restart_idle: got %h expected %h",
               {bus.state, bus.game_over, bus.pipe_init, bus.score}, {S_IDLE, 1'b0, 1'b1, 8'h99});
    end
  endtask

  task automatic test_drop();
    frame(1'b1, 11'd500, 10'd150, 11'd100, 10'd200);
    frame(1'b0, 11'd300, 10'd150, 11'd100, 10'd200);
    checks++;
    if ({bus.state, bus.score} !== {S_PLAY, 8'h00}) begin
      errors++;
      $display("[TB] FAIL new_game: got %h expected %h", {bus.state, bus.score}, {S_PLAY, 8'h00});
    end
    // Accepted safe tick, then hit-causing ticks while S2/S3 are busy.
    @(posedge clk); #1;
    bus.pipe_x = 11'd300; bus.player_y = 10'd200; bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.pipe_x = 11'd110; bus.player_y = 10'd100;
    repeat (2) @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== S_PLAY) begin
      errors++;
      $display("[TB] FAIL busy_tick_drop: got %h expected %h", bus.state, S_PLAY);
    end
  endtask

  task automatic test_ground();
    frame(1'b0, 11'd60, 10'd150, 11'd100, 10'd200);
    frame(1'b0, 11'd300, 10'd150, 11'd100, 10'd439);
    checks++;
    if ({bus.state, bus.score} !== {S_PLAY, 8'h01}) begin
      errors++;
      $display("[TB] FAIL ground_clear: got %h expected %h", {bus.state, bus.score}, {S_PLAY, 8'h01});
    end
    frame(1'b0, 11'd300, 10'd150, 11'd100, 10'd441);
    checks++;
    if ({bus.state, bus.score} !== {S_HIT, 8'h01}) begin
      errors++;
      $display("[TB] FAIL ground_hit: got %h expected %h", {bus.state, bus.score}, {S_HIT, 8'h01});
    end
  endtask

  task automatic test_reset_mid_hit();
    frame(1'b0, 11'd300, 10'd150, 11'd100, 10'd441);
    checks++;
    if ({bus.state, bus.hit_flash} !== {S_HIT, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pre_reset_hit: got %h expected %h", {bus.state, bus.hit_flash}, {S_HIT, 1'b1});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.score, bus.pipe_init, bus.hit_flash, bus.game_over} !== {S_IDLE, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h",
               {bus.state, bus.score, bus.pipe_init, bus.hit_flash, bus.game_over}, {S_IDLE, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

`ifdef BEST_SCORE_EN
  task automatic play_game(input int n);
    frame(1'b1, 11'd200, 10'd150, 11'd100, 10'd200);
    frame(1'b0, 11'd200, 10'd150, 11'd100, 10'd200);
    for (int i = 0; i < n; i++) begin
      frame(1'b0, 11'd60, 10'd150, 11'd100, 10'd200);
      frame(1'b0, 11'd200, 10'd150, 11'd100, 10'd200);
    end
    frame(1'b0, 11'd110, 10'd150, 11'd100, 10'd100);
    repeat (30) frame(1'b0, 11'd110, 10'd150, 11'd100, 10'd100);
  endtask

  task automatic test_best_score();
    checks++;
    if (bus.best_score !== 8'h00) begin
      errors++;
      $display("[TB] FAIL best_reset: got %h expected %h", bus.best_score, 8'h00);
    end
    play_game(5);
    checks++;
    if ({bus.state, bus.score, bus.best_score} !== {S_OVER, 8'h05, 8'h05}) begin
      errors++;
      $display("[TB] FAIL best_first: got %h expected %h", {bus.state, bus.score, bus.best_score}, {S_OVER, 8'h05, 8'h05});
    end
    frame(1'b0, 11'd500, 10'd150, 11'd100, 10'd200);
    frame(1'b1, 11'd500, 10'd150, 11'd100, 10'd200);
    play_game(3);
    checks++;
    if ({bus.state, bus.score, bus.best_score} !== {S_OVER, 8'h03, 8'h05}) begin
      errors++;
      $display("[TB] FAIL best_kept: got %h expected %h", {bus.state, bus.score, bus.best_score}, {S_OVER, 8'h03, 8'h05});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_scoring();
    test_bcd();
    test_hit_sequence();
    test_restart_qualify();
    test_drop();
    test_ground();
    test_reset_mid_hit();
`ifdef BEST_SCORE_EN
    test_best_score();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
